// File: rtl/nav_position_unit.sv
// Multi-axis position integrator: per-axis velocity scaling, saturating/wrapping
// position accumulation and a charge/execute/cooldown jump sequencer.
module nav_position_unit #(
  parameter int K               = 16,
  parameter int AXES            = 3,
  parameter int CHARGE_CYCLES   = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int SATURATE        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        pos_mode,
  input  logic [3:0]        ship_mode,
  input  logic [AXES*K-1:0] speed,
  input  logic [AXES*K-1:0] jump_position,
  output logic [AXES*K-1:0] position,
  output logic [AXES*K-1:0] velocity,
  output logic [1:0]        state,
  output logic              jump_done,
  output logic              ovf,
  output logic              mode_err
);

  localparam int W       = AXES * K;
  localparam int CNT_MAX = (CHARGE_CYCLES > COOLDOWN_CYCLES) ? CHARGE_CYCLES : COOLDOWN_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [3:0] PM_ZERO = 4'b0001;
  localparam logic [3:0] PM_SUB  = 4'b0010;
  localparam logic [3:0] PM_JUMP = 4'b0100;

  localparam logic [3:0] SM_ATTACK  = 4'b0010;
  localparam logic [3:0] SM_DEFENSE = 4'b0100;
  localparam logic [3:0] SM_STEALTH = 4'b1000;

  typedef enum logic [1:0] {
    ST_CRUISE   = 2'd0,
    ST_CHARGE   = 2'd1,
    ST_EXEC     = 2'd2,
    ST_COOLDOWN = 2'd3
  } nav_state_e;

  nav_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    target_q, target_d;
  logic [W-1:0]    pos_d;
  logic            jd_d;
  logic            ovf_set;
  logic            mode_bad;
  logic [W-1:0]    sum_all;
  logic [AXES-1:0] axis_ovf;

  for (genvar a = 0; a < AXES; a++) begin : g_axis
    logic signed [K-1:0] spd_a;
    logic signed [K-1:0] vel_a;
    logic signed [K-1:0] pos_a;
    logic signed [K-1:0] sum_a;
    logic signed [K:0]   sum_w;

    assign spd_a = speed[a*K +: K];
    assign pos_a = position[a*K +: K];

    always_comb begin
      case (ship_mode)
        SM_ATTACK:  vel_a = spd_a;
        SM_DEFENSE: vel_a = spd_a >>> 1;
        SM_STEALTH: vel_a = spd_a >>> 2;
        default:    vel_a = '0;
      endcase
    end

    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    assign sum_w       = {pos_a[K-1], pos_a} + {vel_a[K-1], vel_a};
    assign axis_ovf[a] = sum_w[K] ^ sum_w[K-1];

    always_comb begin
      sum_a = sum_w[K-1:0];
      if (axis_ovf[a] && (SATURATE != 0)) begin
        sum_a = sum_w[K] ? {1'b1, {(K-1){1'b0}}} : {1'b0, {(K-1){1'b1}}};
      end
    end

    assign velocity[a*K +: K] = vel_a;
    assign sum_all[a*K +: K]  = sum_a;
  end

  assign mode_bad = !$onehot(pos_mode) || !$onehot(ship_mode);
  assign state    = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    pos_d    = position;
    jd_d     = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      ST_CRUISE: begin
        case (pos_mode)
          PM_ZERO: pos_d = '0;
          PM_SUB: begin
            pos_d   = sum_all;
            ovf_set = |axis_ovf;
          end
          PM_JUMP: begin
            target_d = jump_position;
            cnt_d    = CW'(CHARGE_CYCLES - 1);
            state_d  = ST_CHARGE;
          end
          default: ;
        endcase
      end
      ST_CHARGE: begin
        if (pos_mode == PM_ZERO) begin
          pos_d   = '0;
          state_d = ST_CRUISE;
        end else if (cnt_q == '0) begin
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_EXEC: begin
        if (pos_mode == PM_ZERO) begin
          pos_d   = '0;
          state_d = ST_CRUISE;
        end else begin
          pos_d   = target_q;
          jd_d    = 1'b1;
          cnt_d   = CW'(COOLDOWN_CYCLES - 1);
          state_d = ST_COOLDOWN;
        end
      end
      default: begin
        // Jump requests act as hold here; zero never shortens the cooldown.
        case (pos_mode)
          PM_ZERO: pos_d = '0;
          PM_SUB: begin
            pos_d   = sum_all;
            ovf_set = |axis_ovf;
          end
          default: ;
        endcase
        if (cnt_q == '0) begin
          state_d = ST_CRUISE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CRUISE;
      cnt_q     <= '0;
      target_q  <= '0;
      position  <= '0;
      jump_done <= 1'b0;
      ovf       <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      position  <= pos_d;
      jump_done <= jd_d;
      ovf       <= ovf | ovf_set;
      mode_err  <= mode_err | mode_bad;
    end
  end

endmodule

// File: doc/nav_position_unit.md
Name: nav_position_unit

Overview:
- Next-generation multi-axis position integrator for the command module. It merges per-axis velocity scaling and position accumulation into one registered block, with parametrised width and axis count.
- New features: signed saturating arithmetic, a jump sequencer (charge, execute, cooldown), and invalid-mode detection.
- Sits between the ship-mode controller and the navigation/telemetry consumers.

Parameters:
- K, 16, per-axis word width (signed two's complement).
- AXES, 3, number of axes; packed vectors are {X, Y, Z, ...}, with axis 0 in the LSBs.
- CHARGE_CYCLES, 4, number of cycles spent in CHARGE before a jump executes (>=1).
- COOLDOWN_CYCLES, 8, number of cycles after a jump during which new jump requests are ignored (>=1).
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pos_mode  in  4  one-hot position command: 0001 zero, 0010 sublight, 0100 jump, 1000 hold.
- ship_mode  in  4  one-hot ship mode: 0001 stop, 0010 attack, 0100 defense, 1000 stealth.
- speed  in  AXES*K  signed per-axis base speed.
- jump_position  in  AXES*K  jump target, sampled only on jump acceptance.
- position  out  AXES*K  registered per-axis position.
- velocity  out  AXES*K  combinational scaled velocity.
- state  out  2  0 CRUISE, 1 CHARGE, 2 EXEC, 3 COOLDOWN.
- jump_done  out  1  one-cycle pulse when the jump is applied.
- ovf  out  1  sticky flag; set when any axis saturated or wrapped.
- mode_err  out  1  sticky flag; set on a non-one-hot pos_mode or ship_mode.

Behaviour:
- Reset (rst_n low, async): position=0, state=CRUISE, target=0, counter=0, jump_done=0, ovf=0, mode_err=0.
- Velocity scaling (per axis, combinational, arithmetic shift):
  - stop -> 0
  - attack -> speed
  - defense -> speed>>>1
  - stealth -> speed>>>2
  - non-one-hot ship_mode -> 0, and mode_err set at the next edge.
- Sublight update: position <= position + velocity, computed at K+1 bits.
  - On signed overflow with SATURATE=1: clamp to +2^(K-1)-1 or -2^(K-1).
  - With SATURATE=0: keep the low K bits.
  - Either case sets ovf.
- Latency: inputs sampled at edge n appear on position after edge n. No combinational path to position.
- CRUISE:
  - 0001 -> position=0.
  - 0010 -> sublight update.
  - 1000 -> hold.
  - 0100 -> latch target<=jump_position, counter<=CHARGE_CYCLES-1, go to CHARGE; position holds this cycle.
  - Invalid pos_mode -> hold and set mode_err.
- CHARGE:
  - Position holds regardless of pos_mode, except 0001.
  - 0001 aborts: position=0, state=CRUISE, no jump_done.
  - Otherwise decrement counter; when counter==0, go to EXEC.
  - A jump_position change during CHARGE is ignored.
- EXEC: lasts one cycle.
  - position<=target, jump_done=1 (asserted for this cycle only).
  - counter<=COOLDOWN_CYCLES-1, go to COOLDOWN.
  - 0001 during EXEC takes priority: position=0, state=CRUISE, no pulse.
- COOLDOWN:
  - Behaves like CRUISE for 0001/0010/1000.
  - 0100 is treated as hold (not latched).
  - Decrement counter; at 0, go to CRUISE.
  - 0001 does not shorten the cooldown.
- Jump requests are level-sensitive: 0100 held through COOLDOWN starts a new charge on the first CRUISE cycle.
- Sticky flags (ovf, mode_err) clear only on reset.
- Reset mid-operation: immediate return to reset values. Any in-flight jump is lost.

Test Plan:
- Reset then sublight: K=16, speed X=100, attack for 3 cycles -> X position 100, 200, 300; stop -> holds 300.
- Mode scaling: speed X=-8. Attack -> velocity -8; defense -> -4; stealth -> -2; stop -> 0; ship_mode 0110 -> 0, with mode_err=1 the following cycle.
- Saturation: position X=32760, velocity 100. SATURATE=1 -> 32767 with ovf=1. SATURATE=0 -> -32676 with ovf=1.
- Jump: target {500,-500,7} presented with 0100 at cycle 0 -> state CHARGE for cycles 1-4, EXEC at cycle 5, position={500,-500,7} and jump_done=1 after that edge. COOLDOWN lasts 8 cycles; 0100 held throughout is ignored, then recharges.
- Abort: 0001 in the 2nd CHARGE cycle -> position=0, state=CRUISE, jump_done never asserted.
- Async reset: rst_n pulsed low mid-COOLDOWN, between clock edges -> all outputs reset immediately, without waiting for an edge.
